// File: rtl/ps2_arrow_keys_if.sv
// PS/2 receiver bus: raw keyboard pins in, decoded byte/strobes/arrow levels out.
// The master side is whoever owns the keyboard pins and consumes the results.
// The slave side is the receiver itself.
interface ps2_arrow_keys_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic       u_arr;
  logic       l_arr;
  logic       d_arr;
  logic       r_arr;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scan_code,
    input  scan_valid,
    input  frame_err,
    input  u_arr,
    input  l_arr,
    input  d_arr,
    input  r_arr
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scan_code,
    output scan_valid,
    output frame_err,
    output u_arr,
    output l_arr,
    output d_arr,
    output r_arr
  );
endinterface

// File: rtl/ps2_arrow_keys.sv
// PS/2 keyboard receiver and arrow-key decoder in the 25 MHz pixel clock domain.
// Raw pins are synchronised, the clock is glitch-filtered, 11-bit frames are
// deframed on filtered falling edges with start/parity/stop/timeout checks,
// and E0/F0-prefixed arrow make/break codes drive four level flags.
module ps2_arrow_keys #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         vga_clk,
  input  logic         reset,
  ps2_arrow_keys_if.slave bus
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RX    = 2'd1;
  localparam logic [1:0]  S_STOP  = 2'd2;

  localparam logic [3:0]  FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  PAR_IDX  = 4'd8;

  // Input conditioning state
  logic        r_clk_s1;
  logic        r_clk_s2;
  logic        r_dat_s1;
  logic        r_dat_s2;
  logic        r_clk_flt;
  logic        r_dat_flt;
  logic [3:0]  r_flt_cnt;

  // Deframer state
  logic [1:0]  r_state;
  logic [3:0]  r_bit_cnt;
  logic [8:0]  r_shift;
  logic [15:0] r_to_cnt;

  // Receiver outputs
  logic [7:0]  r_scan_code;
  logic        r_scan_valid;
  logic        r_frame_err;

  // Decoder state
  logic        r_ext;
  logic        r_brk;
  logic        r_u_arr;
  logic        r_l_arr;
  logic        r_d_arr;
  logic        r_r_arr;

  logic        w_flt_flip;
  logic        w_fall;
  logic        w_frame_ok;
  logic        w_timeout;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample;
  // a flip from high is the falling-edge event the deframer samples data on.
  assign w_flt_flip = (r_clk_s2 != r_clk_flt) && (r_flt_cnt == FLT_LAST);
  assign w_fall     = w_flt_flip && r_clk_flt;

  // Stop bit high and odd parity across the eight data bits plus parity bit.
  assign w_frame_ok = r_dat_flt && (^r_shift);

  // The timeout counter measures cycles since the last falling edge.
  assign w_timeout  = (r_to_cnt == TO_LAST);

  // Two-flop synchronisers on both raw pins; idle bus level is high.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock glitch filter: count consecutive samples that disagree with the
  // filtered level; any agreeing sample restarts the count.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_clk_flt <= 1'b1;
      r_dat_flt <= 1'b1;
      r_flt_cnt <= 4'd0;
    end else begin
      r_dat_flt <= r_dat_s2;
      if (r_clk_s2 == r_clk_flt) begin
        r_flt_cnt <= 4'd0;
      end else if (w_flt_flip) begin
        r_clk_flt <= r_clk_s2;
        r_flt_cnt <= 4'd0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 4'd1;
      end
    end
  end

  // Deframer: start bit, 8 data bits LSB first, parity, stop; aborts on timeout.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 9'd0;
      r_to_cnt     <= 16'd0;
      r_scan_code  <= 8'h00;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= 16'd0;
          if (w_fall) begin
            if (!r_dat_flt) begin
              r_state   <= S_RX;
              r_bit_cnt <= 4'd0;
            end else begin
              // A falling edge with data high cannot be a start bit.
              r_frame_err <= 1'b1;
            end
          end
        end
        S_RX: begin
          if (w_fall) begin
            r_to_cnt  <= 16'd0;
            r_shift   <= {r_dat_flt, r_shift[8:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == PAR_IDX) begin
              r_state <= S_STOP;
            end
          end else if (w_timeout) begin
            r_to_cnt    <= 16'd0;
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_to_cnt <= 16'd0;
            r_state  <= S_IDLE;
            if (w_frame_ok) begin
              r_scan_code  <= r_shift[7:0];
              r_scan_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_to_cnt    <= 16'd0;
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_to_cnt <= 16'd0;
        end
      endcase
    end
  end

  // Prefix tracking and arrow level flags; acts the cycle after each strobe.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_u_arr <= 1'b0;
      r_l_arr <= 1'b0;
      r_d_arr <= 1'b0;
      r_r_arr <= 1'b0;
    end else if (r_frame_err) begin
      // A broken frame may have been part of a prefixed sequence; forget it.
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_scan_valid) begin
      case (r_scan_code)
        8'hE0: r_ext <= 1'b1;
        8'hF0: r_brk <= 1'b1;
        default: begin
          if (r_ext) begin
            case (r_scan_code)
              8'h75:   r_u_arr <= ~r_brk;
              8'h6B:   r_l_arr <= ~r_brk;
              8'h72:   r_d_arr <= ~r_brk;
              8'h74:   r_r_arr <= ~r_brk;
              default: ;
            endcase
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scan_code  = r_scan_code;
  assign bus.scan_valid = r_scan_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.u_arr      = r_u_arr;
  assign bus.l_arr      = r_l_arr;
  assign bus.d_arr      = r_d_arr;
  assign bus.r_arr      = r_r_arr;

endmodule
